// File: rtl/pattern_scan_ctrl_if.sv
// Word-level scan handshake plus bit-serial output bundle for pattern_scan_ctrl.
// The master drives the start request and the word/pattern/overlap operands.
// The slave (the controller) drives status, the serial stream and the results.
interface pattern_scan_ctrl_if #(
    parameter int WORD_W = 16,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 5,
    parameter int IDX_W  = 4
);
    logic              start;
    logic [WORD_W-1:0] word;
    logic [PAT_W-1:0]  pattern;
    logic              overlap;
    logic              busy;
    logic              done;
    logic              bit_out;
    logic              bit_vld;
    logic [CNT_W-1:0]  match_cnt;
    logic              found;
    logic [IDX_W-1:0]  first_idx;

    modport master (
        output start, word, pattern, overlap,
        input  busy, done, bit_out, bit_vld, match_cnt, found, first_idx
    );

    modport slave (
        input  start, word, pattern, overlap,
        output busy, done, bit_out, bit_vld, match_cnt, found, first_idx
    );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Serialises a captured word MSB-first and counts shift-window pattern matches.
// Latency: start accepted at E0, bit k valid after Ek, done WORD_W+1 cycles after start.
// No backpressure: the stream runs without bubbles; start is ignored (not queued) while busy.
module pattern_scan_ctrl #(
    parameter int WORD_W = 16,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 5,
    parameter int IDX_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    pattern_scan_ctrl_if.slave  scan
);
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Remaining word bits, next bit to present always sits at the MSB.
    logic [WORD_W-1:0] word_sr;
    logic [PAT_W-1:0]  pat_q;
    logic              ovl_q;
    logic [PAT_W-1:0]  win;
    logic [FILL_W-1:0] fill;
    logic [IDX_W-1:0]  idx;
    logic              bit_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              found_q;
    logic [IDX_W-1:0]  first_q;

    logic [PAT_W-1:0]  win_nxt;
    logic [FILL_W-1:0] fill_nxt;
    logic              hit;
    logic              last_bit;
    logic              busy_c;
    logic              done_c;
    logic              vld_c;

    // Window/fill look-ahead for the bit being consumed on this edge.
    always_comb begin
        win_nxt  = {win[PAT_W-2:0], bit_q};
        fill_nxt = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
        hit      = (state == S_SHIFT) && (fill_nxt == FILL_FULL) && (win_nxt == pat_q);
        last_bit = (idx == IDX_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status decode; outputs depend only on the state flop.
    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        vld_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (scan.start) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy_c = 1'b1;
                vld_c  = 1'b1;
                if (last_bit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy_c    = 1'b1;
                done_c    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, serialisation and match accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_sr <= '0;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            win     <= '0;
            fill    <= '0;
            idx     <= '0;
            bit_q   <= 1'b0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            first_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (scan.start) begin
                        bit_q   <= scan.word[WORD_W-1];
                        word_sr <= scan.word << 1;
                        pat_q   <= scan.pattern;
                        ovl_q   <= scan.overlap;
                        win     <= '0;
                        fill    <= '0;
                        idx     <= '0;
                        cnt_q   <= '0;
                        found_q <= 1'b0;
                        first_q <= '0;
                    end
                end
                S_SHIFT: begin
                    win     <= win_nxt;
                    // Non-overlapping mode discards the window contents after a hit.
                    fill    <= (hit && !ovl_q) ? '0 : fill_nxt;
                    idx     <= idx + 1'b1;
                    word_sr <= word_sr << 1;
                    bit_q   <= last_bit ? 1'b0 : word_sr[WORD_W-1];
                    if (hit) begin
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (!found_q) begin
                            found_q <= 1'b1;
                            first_q <= idx;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign scan.busy      = busy_c;
    assign scan.done      = done_c;
    assign scan.bit_vld   = vld_c;
    assign scan.bit_out   = bit_q;
    assign scan.match_cnt = cnt_q;
    assign scan.found     = found_q;
    assign scan.first_idx = first_q;
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: table vectors, hand-written corner sequences, random scans.
// Two instances run the same stimulus: default counter width and a 3-bit saturating one.
// Expected results come from the table or from a match search over the word's bit slices.
module tb_pattern_scan_ctrl;
    localparam int WORD_W = 16;
    localparam int PAT_W  = 4;
    localparam int IDX_W  = 4;
    localparam int CNT_A  = 5;
    localparam int CNT_B  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [WORD_W-1:0] word = '0;
    logic [PAT_W-1:0]  pattern = '0;
    logic              overlap = 1'b0;

    pattern_scan_ctrl_if #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_A), .IDX_W(IDX_W)) ifa ();
    pattern_scan_ctrl_if #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_B), .IDX_W(IDX_W)) ifb ();

    assign ifa.start   = start;
    assign ifa.word    = word;
    assign ifa.pattern = pattern;
    assign ifa.overlap = overlap;
    assign ifb.start   = start;
    assign ifb.word    = word;
    assign ifb.pattern = pattern;
    assign ifb.overlap = overlap;

    pattern_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_A), .IDX_W(IDX_W)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .scan (ifa)
    );

    pattern_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_B), .IDX_W(IDX_W)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .scan (ifb)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [WORD_W-1:0] w;
        logic [PAT_W-1:0]  p;
        logic              ov;
        int                raw;
        logic              fnd;
        int                first;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: slide over every PAT_W-bit slice of the word in stream order; in
    // non-overlapping mode a slice may not reuse any bit of the previous counted match.
    function automatic void ref_scan(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p,
                                     input logic ov, output int cnt, output logic fnd,
                                     output int first);
        int  last_end;
        int  start_pos;
        bit  hit;
        last_end = -1;
        cnt      = 0;
        fnd      = 1'b0;
        first    = 0;
        for (int i = PAT_W - 1; i < WORD_W; i++) begin
            start_pos = i - PAT_W + 1;
            if (!ov && start_pos <= last_end) continue;
            hit = 1'b1;
            for (int j = 0; j < PAT_W; j++) begin
                if (w[WORD_W-1-(start_pos+j)] != p[PAT_W-1-j]) hit = 1'b0;
            end
            if (hit) begin
                cnt++;
                if (!fnd) first = i;
                fnd      = 1'b1;
                last_end = i;
            end
        end
    endfunction

    task automatic check_results(input string tag, input int raw, input logic fnd, input int first);
        int exp_a;
        int exp_b;
        exp_a = (raw > 31) ? 31 : raw;
        exp_b = (raw > 7) ? 7 : raw;
        check({tag, " cnt_a"},   32'(ifa.match_cnt), 32'(exp_a));
        check({tag, " cnt_b"},   32'(ifb.match_cnt), 32'(exp_b));
        check({tag, " found_a"}, 32'(ifa.found),     32'(fnd));
        check({tag, " found_b"}, 32'(ifb.found),     32'(fnd));
        check({tag, " first_a"}, 32'(ifa.first_idx), 32'(first));
        check({tag, " first_b"}, 32'(ifb.first_idx), 32'(first));
    endtask

    // One full scan from IDLE; operands are scrambled after acceptance and an
    // optional stray start pulse is raised during bit cycle pulse_at.
    task automatic do_scan(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p, input logic ov,
                           input int raw, input logic fnd, input int first,
                           input int pulse_at, input string tag);
        logic [WORD_W-1:0] stream;
        int vld_ok;
        int busy_ok;
        int done_cnt;
        @(negedge clk);
        start   = 1'b1;
        word    = w;
        pattern = p;
        overlap = ov;
        @(posedge clk);
        #1;
        start   = 1'b0;
        word    = WORD_W'($urandom);
        pattern = PAT_W'($urandom);
        overlap = 1'($urandom);
        stream   = '0;
        vld_ok   = 1;
        busy_ok  = 1;
        done_cnt = 0;
        for (int k = 0; k < WORD_W; k++) begin
            @(negedge clk);
            stream = {stream[WORD_W-2:0], ifa.bit_out};
            if (!(ifa.bit_vld === 1'b1 && ifb.bit_vld === 1'b1)) vld_ok = 0;
            if (!(ifa.busy === 1'b1 && ifb.busy === 1'b1)) busy_ok = 0;
            if (ifa.done !== 1'b0) done_cnt++;
            start = (k == pulse_at);
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, " stream"},  32'(stream), 32'(w));
        check({tag, " vld_run"}, 32'(vld_ok), 32'd1);
        check({tag, " busy_run"}, 32'(busy_ok), 32'd1);
        check({tag, " done_a"},  32'(ifa.done), 32'd1);
        check({tag, " done_b"},  32'(ifb.done), 32'd1);
        check({tag, " vld_at_done"}, 32'(ifa.bit_vld), 32'd0);
        check({tag, " busy_at_done"}, 32'(ifa.busy), 32'd1);
        check_results(tag, raw, fnd, first);
        if (ifa.done === 1'b1) done_cnt++;
        @(negedge clk);
        if (ifa.done !== 1'b0) done_cnt++;
        check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, " busy_after"}, 32'(ifa.busy), 32'd0);
        check_results({tag, " hold"}, raw, fnd, first);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int raw;
        logic fnd;
        int first;
        int dtimes[$];
        int ncyc;
        logic [WORD_W-1:0] w;
        logic [PAT_W-1:0]  p;
        logic [WORD_W-1:0] tmp;
        logic ov;
        int pulse;

        tbl[0] = '{16'hDDDD, 4'b1101, 1'b1, 4,  1'b1, 3};
        tbl[1] = '{16'hAAAA, 4'b1010, 1'b1, 7,  1'b1, 3};
        tbl[2] = '{16'hAAAA, 4'b1010, 1'b0, 4,  1'b1, 3};
        tbl[3] = '{16'h0000, 4'b1101, 1'b1, 0,  1'b0, 0};
        tbl[4] = '{16'hFFFF, 4'b1111, 1'b1, 13, 1'b1, 3};
        tbl[5] = '{16'hFFFF, 4'b1111, 1'b0, 4,  1'b1, 3};
        tbl[6] = '{16'h000D, 4'b1101, 1'b1, 1,  1'b1, 15};
        tbl[7] = '{16'h0B00, 4'b1011, 1'b0, 1,  1'b1, 7};

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst busy",    32'(ifa.busy),      32'd0);
        check("rst done",    32'(ifa.done),      32'd0);
        check("rst vld",     32'(ifa.bit_vld),   32'd0);
        check("rst bit_out", 32'(ifa.bit_out),   32'd0);
        check("rst cnt",     32'(ifa.match_cnt), 32'd0);
        check("rst found",   32'(ifa.found),     32'd0);
        check("rst first",   32'(ifa.first_idx), 32'd0);
        check("rst busy_b",  32'(ifb.busy),      32'd0);
        rst = 1'b0;

        // Table vectors.
        for (int i = 0; i < 8; i++) begin
            do_scan(tbl[i].w, tbl[i].p, tbl[i].ov, tbl[i].raw, tbl[i].fnd, tbl[i].first,
                    -1, $sformatf("vec%0d", i));
        end

        // Stray start in the middle of a scan is ignored.
        do_scan(16'hDDDD, 4'b1101, 1'b1, 4, 1'b1, 3, 5, "pulse5");

        // Start held high: back-to-back scans at the minimum period.
        @(negedge clk);
        start   = 1'b1;
        word    = 16'hAAAA;
        pattern = 4'b1010;
        overlap = 1'b0;
        ncyc = 0;
        while (dtimes.size() < 2 && ncyc < 60) begin
            @(negedge clk);
            ncyc++;
            if (ifa.done === 1'b1) begin
                dtimes.push_back(ncyc);
                if (dtimes.size() == 2) begin
                    start = 1'b0;
                    check_results("held", 4, 1'b1, 3);
                end
            end
        end
        start = 1'b0;
        check("held done_count", 32'(dtimes.size()), 32'd2);
        if (dtimes.size() == 2) begin
            check("held first_done", 32'(dtimes[0]), 32'(WORD_W + 1));
            check("held period", 32'(dtimes[1] - dtimes[0]), 32'(WORD_W + 2));
        end
        @(negedge clk);
        check("held idle", 32'(ifa.busy), 32'd0);

        // Reset in the middle of a scan.
        @(negedge clk);
        start   = 1'b1;
        word    = 16'hDDDD;
        pattern = 4'b1101;
        overlap = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("midrst pre_cnt", 32'(ifa.match_cnt), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy",  32'(ifa.busy),      32'd0);
        check("midrst vld",   32'(ifa.bit_vld),   32'd0);
        check("midrst cnt",   32'(ifa.match_cnt), 32'd0);
        check("midrst found", 32'(ifa.found),     32'd0);
        check("midrst done",  32'(ifa.done),      32'd0);
        check("midrst bit",   32'(ifa.bit_out),   32'd0);
        rst = 1'b0;
        do_scan(16'hAAAA, 4'b1010, 1'b1, 7, 1'b1, 3, -1, "postrst");

        // Random scans against the reference search.
        for (int n = 0; n < 40; n++) begin
            w  = WORD_W'($urandom);
            ov = 1'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                p = PAT_W'($urandom);
            end else begin
                tmp = w >> $urandom_range(0, WORD_W - PAT_W);
                p   = tmp[PAT_W-1:0];
            end
            pulse = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WORD_W - 1)) : -1;
            ref_scan(w, p, ov, raw, fnd, first);
            do_scan(w, p, ov, raw, fnd, first, pulse, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Sequencing controller for the serial pattern-recogniser datapath. It accepts a parallel data word and a programmable target pattern on a start/busy/done handshake, then serialises the word MSB-first, one bit per clock, to the recogniser input. It runs an internal shift-window matcher on the same bit stream and reports the match count and the first-match position. It sits between the word-level control logic and the bit-serial detectors, so one detector datapath can be reused per word without software bit-banging.

## Interface
- WORD_W, 16: bits per scanned word; ≥ PAT_W.
- PAT_W, 4: pattern length in bits; ≥ 2.
- CNT_W, 5: match counter width; saturating.
- IDX_W, 4: bit-index width; ≥ clog2(WORD_W).

- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request scan; sampled only in IDLE
- word  in  WORD_W  data word; captured when start accepted
- pattern  in  PAT_W  target pattern, MSB = first bit expected; captured with word
- overlap  in  1  1 = overlapping matches counted, 0 = non-overlapping; captured with word
- busy  out  1  high from acceptance until return to IDLE
- done  out  1  one-cycle pulse, results valid
- bit_out  out  1  serial bit to recogniser datapath
- bit_vld  out  1  bit_out valid this cycle
- match_cnt  out  CNT_W  number of matches in last scan
- found  out  1  at least one match in last scan
- first_idx  out  IDX_W  stream index (0 = word MSB) of the bit completing the first match

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0, bit_vld=0. start=1 → capture word, pattern, overlap; clear match_cnt, found, first_idx, window, fill count, bit index; go to SHIFT.
- SHIFT: bit_vld=1, bit_out = captured word bit [WORD_W-1-idx]. Each edge:
  - The window shifts left and takes bit_out in.
  - The fill count increments, saturating at PAT_W.
  - idx increments.
- Match condition: fill count (after update) = PAT_W and window = pattern.
- On match:
  - match_cnt increments, saturating at 2^CNT_W-1.
  - If found was 0, first_idx = idx of the bit just consumed and found = 1.
  - If overlap=0, the fill count resets to 0, so the next match needs PAT_W fresh bits.
- After the bit with idx = WORD_W-1 is consumed → DONE.
- DONE: done=1, busy=1, bit_vld=0. Next edge → IDLE.
- Results (match_cnt, found, first_idx) hold from DONE until the next accepted start.
- start while busy=1: ignored, no effect on the current scan, and not queued.
- start high continuously: a new scan is accepted on the first IDLE cycle after DONE.
- word, pattern and overlap changing during a scan: no effect.
- Unused state encodings → IDLE.

## Timing
- Reset (any state, including mid-scan) → IDLE next edge. At that edge busy=0, done=0, bit_vld=0, bit_out=0, match_cnt=0, found=0, first_idx=0.
- start high at edge E0 → busy=1 and bit 0 on bit_out after E0.
- Bits 0..WORD_W-1 are presented in cycles E0..E(WORD_W-1), one per cycle, no bubbles.
- done=1 in the cycle after E(WORD_W), with results valid in that same cycle.
- busy=0 after E(WORD_W+1).
- Scan latency, start to done: WORD_W+1 cycles. Minimum start-to-start period: WORD_W+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then word=16'hDDDD, pattern=4'b1101, overlap=1 → bit_out sequence 1101×4 over 16 consecutive bit_vld cycles; done 17 cycles after start; match_cnt=4, found=1, first_idx=3.
- word=16'hAAAA, pattern=4'b1010: with overlap=1 → match_cnt=7, first_idx=3; then with overlap=0 → match_cnt=4, first_idx=3.
- word=16'h0000, pattern=4'b1101 → match_cnt=0, found=0, first_idx=0; done still pulses exactly once.
- CNT_W=3, word=16'hFFFF, pattern=4'hF, overlap=1 → 13 raw matches saturate to match_cnt=7; first_idx=3.
- start pulsed at bit 5 of a scan → ignored; results match an undisturbed scan. start held high → back-to-back scans with period 18 cycles.
- rst asserted at bit 8 of a scan → next cycle busy=0, bit_vld=0, match_cnt=0, found=0. A following start then scans normally.
